// File: rtl/vga_sfifo_pkg.sv
// ---------------------------------------------------------------------------
// vga_fifo_pkg
// Shared helpers for the VGA pixel/command FIFOs (single-clock and async).
//   clog2      : ceiling log2 usable in parameter expressions
//   cnt_width  : width of an occupancy counter able to hold 0..depth
//   ptr_inc    : binary pointer increment with explicit wrap at last_index,
//                so any depth (including non-power-of-two) works
// ---------------------------------------------------------------------------
package vga_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                            input logic [31:0] last_index);
        return (ptr == last_index) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/vga_sfifo_if.sv
// ---------------------------------------------------------------------------
// vga_sfifo_if
// Valid/ready bus bundle for vga_sfifo.
//   src_vld/src_rdy/src_data : write side
//   dst_vld/dst_rdy/dst_data : read side
// Modports: slave = FIFO view, master = surrounding logic view.
// ---------------------------------------------------------------------------
interface vga_sfifo_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  src_vld;
    logic                  src_rdy;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  dst_vld;
    logic                  dst_rdy;
    logic [DATA_WIDTH-1:0] dst_data;

    modport master (
        output src_vld, src_data, dst_rdy,
        input  src_rdy, dst_vld, dst_data
    );

    modport slave (
        input  src_vld, src_data, dst_rdy,
        output src_rdy, dst_vld, dst_data
    );
endinterface

// File: rtl/vga_sfifo_ostage.sv
// ---------------------------------------------------------------------------
// vga_sfifo_ostage
// Registered output stage of vga_sfifo (REG_OUT=1). Holds the head word.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear of the held word
//   dst_rdy    : consumer accept
//   mem_empty  : backing memory holds no words
//   mem_data   : word at the memory read pointer
//   wr         : write handshake this cycle (already masked by flush)
//   src_data   : write payload, used when bypassing memory
//   out_vld    : head word valid (drives dst_vld)
//   out_data   : head word (drives dst_data)
//   pop        : memory read pointer advances
//   bypass     : write goes straight into this register, not into memory
// ---------------------------------------------------------------------------
module vga_sfifo_ostage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  dst_rdy,
    input  logic                  mem_empty,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  pop,
    output logic                  bypass
);
    logic load;

    // Register takes a new word when it is empty or its word is consumed.
    assign load   = ~out_vld | dst_rdy;
    assign pop    = load & ~mem_empty & ~flush;
    assign bypass = load & mem_empty & wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (flush) begin
            out_vld  <= 1'b0;
        end else if (load) begin
            if (!mem_empty) begin
                out_vld  <= 1'b1;
                out_data <= mem_data;
            end else if (wr) begin
                out_vld  <= 1'b1;
                out_data <= src_data;
            end else begin
                out_vld  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/vga_sfifo.sv
// ---------------------------------------------------------------------------
// vga_sfifo
// Single-clock valid/ready FIFO of DEPTH entries (any DEPTH >= 2), with
// optional registered output counted in capacity, synchronous flush,
// registered almost-full/almost-empty flags and a sticky peak watermark.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous clear (wins over any handshake)
//   bus (slave)       : src_vld/src_rdy/src_data, dst_vld/dst_rdy/dst_data
//   afull_th/aempty_th: thresholds; afull = cnt >= afull_th,
//                       aempty = cnt <= aempty_th (both registered)
//   cnt               : registered occupancy
//   peak_clr/peak_cnt : watermark reload / sticky maximum occupancy
// ---------------------------------------------------------------------------
module vga_sfifo
    import vga_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int REG_OUT    = 1,
    parameter int NO_RST     = 0,
    parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    vga_sfifo_if.slave           bus,
    input  logic [CNT_WIDTH-1:0] afull_th,
    input  logic [CNT_WIDTH-1:0] aempty_th,
    output logic                 afull,
    output logic                 aempty,
    output logic [CNT_WIDTH-1:0] cnt,
    input  logic                 peak_clr,
    output logic [CNT_WIDTH-1:0] peak_cnt
);
    // With REG_OUT the output register is one of the DEPTH entries.
    localparam int MEM_DEPTH = (REG_OUT != 0) ? DEPTH - 1 : DEPTH;
    localparam int PTR_W     = (clog2(MEM_DEPTH) < 1) ? 1 : clog2(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [31:0]          LAST_IX = 32'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [PTR_W-1:0]      wptr, rptr;
    logic                  src_rdy_q, dst_vld_w;
    logic [DATA_WIDTH-1:0] dst_data_w;
    logic                  wr, rd, mem_wr, mem_rd, bypass;
    logic [CNT_WIDTH-1:0]  cnt_nxt, peak_nxt;

    // Flush discards both handshakes of its cycle.
    assign wr     = bus.src_vld & src_rdy_q & ~flush;
    assign rd     = dst_vld_w & bus.dst_rdy & ~flush;
    assign mem_wr = wr & ~bypass;

    assign bus.src_rdy  = src_rdy_q;
    assign bus.dst_vld  = dst_vld_w;
    assign bus.dst_data = dst_data_w;

    always_comb begin
        cnt_nxt  = cnt + CNT_WIDTH'(wr) - CNT_WIDTH'(rd);
        if (flush) cnt_nxt = '0;
        peak_nxt = (cnt_nxt > peak_cnt) ? cnt_nxt : peak_cnt;
        if (peak_clr) peak_nxt = cnt_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            src_rdy_q <= 1'b1;
            afull     <= 1'b0;
            aempty    <= 1'b1;
            peak_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            cnt       <= cnt_nxt;
            src_rdy_q <= (cnt_nxt < DEPTH_C);
            afull     <= (cnt_nxt >= afull_th);
            aempty    <= (cnt_nxt <= aempty_th);
            peak_cnt  <= peak_nxt;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (mem_wr) wptr <= PTR_W'(ptr_inc(32'(wptr), LAST_IX));
                if (mem_rd) rptr <= PTR_W'(ptr_inc(32'(rptr), LAST_IX));
            end
        end
    end

    generate
        if (NO_RST != 0) begin : g_mem_nrst
            always_ff @(posedge clk) begin
                if (mem_wr) mem[wptr] <= bus.src_data;
            end
        end else begin : g_mem_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
                end else if (mem_wr) begin
                    mem[wptr] <= bus.src_data;
                end
            end
        end

        if (REG_OUT != 0) begin : g_oreg
            logic mem_empty;
            // Whenever memory holds data the output register is full,
            // so memory occupancy is cnt minus the register's word.
            assign mem_empty = (cnt == CNT_WIDTH'(dst_vld_w));

            vga_sfifo_ostage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_ostage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .dst_rdy  (bus.dst_rdy),
                .mem_empty(mem_empty),
                .mem_data (mem[rptr]),
                .wr       (wr),
                .src_data (bus.src_data),
                .out_vld  (dst_vld_w),
                .out_data (dst_data_w),
                .pop      (mem_rd),
                .bypass   (bypass)
            );
        end else begin : g_comb
            assign dst_vld_w  = (cnt != '0);
            assign dst_data_w = mem[rptr];
            assign mem_rd     = rd;
            assign bypass     = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_vga_sfifo.sv
// ---------------------------------------------------------------------------
// tb_vga_sfifo
// Drives identical stimulus into a REG_OUT=1 and a REG_OUT=0 instance
// (DEPTH=5, DATA_WIDTH=8); both must show the same externally visible
// behaviour. Expected values are hand-written per cycle.
// ---------------------------------------------------------------------------
module tb_vga_sfifo;
    localparam int DW = 8;
    localparam int DP = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          src_vld = 1'b0;
    logic          dst_rdy = 1'b0;
    logic          peak_clr = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic [CW-1:0] afull_th = 3'd4;
    logic [CW-1:0] aempty_th = 3'd1;

    logic          afull1, aempty1, afull0, aempty0;
    logic [CW-1:0] cnt1, peak1, cnt0, peak0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_sfifo_if #(.DATA_WIDTH(DW)) bus1 ();
    vga_sfifo_if #(.DATA_WIDTH(DW)) bus0 ();

    assign bus1.src_vld  = src_vld;
    assign bus1.src_data = src_data;
    assign bus1.dst_rdy  = dst_rdy;
    assign bus0.src_vld  = src_vld;
    assign bus0.src_data = src_data;
    assign bus0.dst_rdy  = dst_rdy;

    vga_sfifo #(.DATA_WIDTH(DW), .DEPTH(DP), .REG_OUT(1), .NO_RST(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1),
        .afull_th(afull_th), .aempty_th(aempty_th),
        .afull(afull1), .aempty(aempty1), .cnt(cnt1),
        .peak_clr(peak_clr), .peak_cnt(peak1)
    );

    vga_sfifo #(.DATA_WIDTH(DW), .DEPTH(DP), .REG_OUT(0), .NO_RST(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0),
        .afull_th(afull_th), .aempty_th(aempty_th),
        .afull(afull0), .aempty(aempty0), .cnt(cnt0),
        .peak_clr(peak_clr), .peak_cnt(peak0)
    );

    typedef struct {
        logic          fl;
        logic          sv;
        logic [DW-1:0] sd;
        logic          dr;
        logic          pc;
        logic          e_rdy;
        logic          e_vld;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cnt;
        logic          e_af;
        logic          e_ae;
        logic [CW-1:0] e_pk;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic sv, input logic [DW-1:0] sd,
                         input logic dr, input logic pc);
        flush    = fl;
        src_vld  = sv;
        src_data = sd;
        dst_rdy  = dr;
        peak_clr = pc;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic rdy, input logic vld,
                                input logic [DW-1:0] data, input logic [CW-1:0] c,
                                input logic af, input logic ae, input logic [CW-1:0] pk);
        chk({tag, " r1.src_rdy"}, 32'(bus1.src_rdy), 32'(rdy));
        chk({tag, " r1.dst_vld"}, 32'(bus1.dst_vld), 32'(vld));
        chk({tag, " r1.cnt"},     32'(cnt1),         32'(c));
        chk({tag, " r1.afull"},   32'(afull1),       32'(af));
        chk({tag, " r1.aempty"},  32'(aempty1),      32'(ae));
        chk({tag, " r1.peak"},    32'(peak1),        32'(pk));
        chk({tag, " r0.src_rdy"}, 32'(bus0.src_rdy), 32'(rdy));
        chk({tag, " r0.dst_vld"}, 32'(bus0.dst_vld), 32'(vld));
        chk({tag, " r0.cnt"},     32'(cnt0),         32'(c));
        chk({tag, " r0.afull"},   32'(afull0),       32'(af));
        chk({tag, " r0.aempty"},  32'(aempty0),      32'(ae));
        chk({tag, " r0.peak"},    32'(peak0),        32'(pk));
        if (vld) begin
            chk({tag, " r1.dst_data"}, 32'(bus1.dst_data), 32'(data));
            chk({tag, " r0.dst_data"}, 32'(bus0.dst_data), 32'(data));
        end
    endtask

    initial begin
        //             fl sv sd     dr pc  rdy vld data   cnt af ae pk
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0, 1'b1, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0, 1'b0, 3'd2};
        tbl[3]  = '{1'b0, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b0, 1'b0, 3'd3};
        tbl[4]  = '{1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4, 1'b1, 1'b0, 3'd4};
        tbl[5]  = '{1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd5, 1'b1, 1'b0, 3'd5};
        tbl[6]  = '{1'b0, 1'b1, 8'h16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd5, 1'b1, 1'b0, 3'd5};
        tbl[7]  = '{1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 3'd4, 1'b1, 1'b0, 3'd5};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 3'd5, 1'b1, 1'b0, 3'd5};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 3'd4, 1'b1, 1'b0, 3'd5};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 3'd3, 1'b0, 1'b0, 3'd5};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 3'd2, 1'b0, 1'b0, 3'd5};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h16, 3'd1, 1'b0, 1'b1, 3'd5};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd5};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0};

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        expect_state("reset", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0);
        chk("reset r1.dst_data", 32'(bus1.dst_data), 32'h0);
        advance();

        // Fill, overfull attempt, simultaneous at full, drain, peak clear
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].fl, tbl[i].sv, tbl[i].sd, tbl[i].dr, tbl[i].pc);
            expect_state($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_data,
                         tbl[i].e_cnt, tbl[i].e_af, tbl[i].e_ae, tbl[i].e_pk);
            advance();
        end

        // Pointer wrap: prime two words, then 13 cycles of write+read at cnt=2
        drive(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        expect_state("prime0", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0);
        advance();
        drive(1'b0, 1'b1, 8'h21, 1'b0, 1'b0);
        expect_state("prime1", 1'b1, 1'b1, 8'h20, 3'd1, 1'b0, 1'b1, 3'd1);
        advance();
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 1'b1, 8'(8'h22 + i), 1'b1, 1'b0);
            expect_state($sformatf("wrap%0d", i), 1'b1, 1'b1, 8'(8'h20 + i), 3'd2, 1'b0, 1'b0, 3'd2);
            advance();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        expect_state("drain0", 1'b1, 1'b1, 8'h2D, 3'd2, 1'b0, 1'b0, 3'd2);
        advance();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        expect_state("drain1", 1'b1, 1'b1, 8'h2E, 3'd1, 1'b0, 1'b1, 3'd2);
        advance();

        // Flush at cnt=3 with both handshakes active
        drive(1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
        expect_state("fill0", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd2);
        advance();
        drive(1'b0, 1'b1, 8'h32, 1'b0, 1'b0);
        expect_state("fill1", 1'b1, 1'b1, 8'h31, 3'd1, 1'b0, 1'b1, 3'd2);
        advance();
        drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        expect_state("fill2", 1'b1, 1'b1, 8'h31, 3'd2, 1'b0, 1'b0, 3'd2);
        advance();
        drive(1'b1, 1'b1, 8'h34, 1'b1, 1'b0);
        expect_state("flush_cyc", 1'b1, 1'b1, 8'h31, 3'd3, 1'b0, 1'b0, 3'd3);
        advance();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        expect_state("post_flush", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd3);
        advance();
        drive(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
        expect_state("peak_clr", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0);
        advance();

        // Threshold changes take effect one cycle later
        afull_th = 3'd0;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        expect_state("bypass", 1'b1, 1'b1, 8'h40, 3'd1, 1'b0, 1'b1, 3'd1);
        advance();
        afull_th  = 3'd4;
        aempty_th = 3'd0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        expect_state("afull_th0", 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 3'd1);
        advance();
        drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        expect_state("afull_th4", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd1);
        advance();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        expect_state("aempty_th0", 1'b1, 1'b1, 8'h55, 3'd1, 1'b0, 1'b0, 3'd1);

        // Asynchronous reset in the middle of a cycle
        #1;
        rst = 1'b1;
        #1;
        expect_state("async_rst", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0);
        chk("async_rst r1.dst_data", 32'(bus1.dst_data), 32'h0);
        advance();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
